// File: rtl/umi_arbiter.sv
// N-to-1 UMI packet arbiter: fixed-priority or round-robin selection, with the
// grant held through stalled beats and multi-beat packets until EOM is accepted.
module umi_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned ROUNDROBIN = 0,
  parameter int unsigned CW         = 32,
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int unsigned EOM_BIT = 22;

  typedef enum logic {ST_FREE, ST_LOCKED} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] locked_grant_q, locked_grant_d;
  logic [N-1:0] rr_mask_q, rr_mask_d;
  logic [N-1:0] masked, pick, grant, sel, mask_after;
  logic         seen;
  logic         accept_eom;

  // Unlocked arbitration: lowest set index of the masked set, else of all requests.
  always_comb begin
    masked = umi_in_valid & rr_mask_q;
    pick   = ((ROUNDROBIN != 0) && (masked != '0)) ? masked : umi_in_valid;
    grant  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i] && (grant == '0)) grant[i] = 1'b1;
    end
  end

  assign sel = (state_q == ST_LOCKED) ? locked_grant_q : grant;

  // AND-OR payload mux; all-zero when nothing is selected.
  always_comb begin
    umi_out_cmd     = '0;
    umi_out_dstaddr = '0;
    umi_out_srcaddr = '0;
    umi_out_data    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      umi_out_cmd     = umi_out_cmd     | ({CW{sel[i]}} & umi_in_cmd[i*CW +: CW]);
      umi_out_dstaddr = umi_out_dstaddr | ({AW{sel[i]}} & umi_in_dstaddr[i*AW +: AW]);
      umi_out_srcaddr = umi_out_srcaddr | ({AW{sel[i]}} & umi_in_srcaddr[i*AW +: AW]);
      umi_out_data    = umi_out_data    | ({DW{sel[i]}} & umi_in_data[i*DW +: DW]);
    end
  end

  assign umi_out_valid = |(sel & umi_in_valid);
  assign umi_in_ready  = sel & {N{umi_out_ready}};
  assign accept_eom    = umi_out_valid & umi_out_ready & umi_out_cmd[EOM_BIT];

  // Mask of ports strictly above the current owner; wraps to all ones after the top port.
  always_comb begin
    seen       = 1'b0;
    mask_after = '0;
    for (int unsigned j = 0; j < N; j++) begin
      mask_after[j] = seen;
      seen          = seen | sel[j];
    end
    if (sel[N-1]) mask_after = '1;
  end

  always_comb begin
    state_d        = state_q;
    locked_grant_d = locked_grant_q;
    rr_mask_d      = rr_mask_q;
    if (umi_out_valid) begin
      if (accept_eom) begin
        state_d = ST_FREE;
        if (ROUNDROBIN != 0) rr_mask_d = mask_after;
      end else begin
        state_d        = ST_LOCKED;
        locked_grant_d = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_FREE;
      locked_grant_q <= '0;
      rr_mask_q      <= '1;
    end else begin
      state_q        <= state_d;
      locked_grant_q <= locked_grant_d;
      rr_mask_q      <= rr_mask_d;
    end
  end

endmodule

// File: tb/tb_umi_arbiter.sv
// Directed bench for umi_arbiter: one fixed-priority and one round-robin instance
// share the input stimulus; each scenario checks the instance it targets.
module tb_umi_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dst;
  logic [N*AW-1:0] in_src;
  logic [N*DW-1:0] in_data;
  logic            out_ready;

  logic [N-1:0]  f_ready, r_ready;
  logic          f_valid, r_valid;
  logic [CW-1:0] f_cmd, r_cmd;
  logic [AW-1:0] f_dst, r_dst, f_src, r_src;
  logic [DW-1:0] f_data, r_data;

  int errors = 0;
  int checks = 0;

  umi_arbiter #(.N(N), .ROUNDROBIN(0), .CW(CW), .AW(AW), .DW(DW)) u_fix (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(f_ready),
    .umi_out_valid(f_valid), .umi_out_cmd(f_cmd), .umi_out_dstaddr(f_dst),
    .umi_out_srcaddr(f_src), .umi_out_data(f_data), .umi_out_ready(out_ready)
  );

  umi_arbiter #(.N(N), .ROUNDROBIN(1), .CW(CW), .AW(AW), .DW(DW)) u_rr (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(r_ready),
    .umi_out_valid(r_valid), .umi_out_cmd(r_cmd), .umi_out_dstaddr(r_dst),
    .umi_out_srcaddr(r_src), .umi_out_data(r_data), .umi_out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] pcmd(input int p, input logic e);
    return (32'h0000_0100 + 32'(p)) | (32'(e) << 22);
  endfunction
  function automatic logic [AW-1:0] pdst(input int p);
    return 64'hA000_0000_0000_0000 + 64'(p);
  endfunction
  function automatic logic [AW-1:0] psrc(input int p);
    return 64'h5000_0000_0000_0000 + 64'(p);
  endfunction
  function automatic logic [DW-1:0] pdata(input int p);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(p);
    return {w, w, w, w};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] e, input logic r);
    for (int i = 0; i < 4; i++) begin
      in_cmd[i*CW +: CW]  = pcmd(i, e[i]);
      in_dst[i*AW +: AW]  = pdst(i);
      in_src[i*AW +: AW]  = psrc(i);
      in_data[i*DW +: DW] = pdata(i);
    end
    in_valid  = v;
    out_ready = r;
  endtask

  // Advance one clock, apply new inputs shortly after the edge, let them settle.
  task automatic cyc(input logic [3:0] v, input logic [3:0] e, input logic r);
    @(posedge clk);
    #1;
    drive(v, e, r);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // p < 0 means nothing selected: payload must be all zero.
  task automatic expect_out(input string tag, input bit rr, input logic ov,
                            input logic [3:0] rdy, input int p, input logic pe);
    logic          a_valid;
    logic [3:0]    a_ready;
    logic [CW-1:0] a_cmd;
    logic [AW-1:0] a_dst, a_src;
    logic [DW-1:0] a_data;
    a_valid = rr ? r_valid : f_valid;
    a_ready = rr ? r_ready : f_ready;
    a_cmd   = rr ? r_cmd   : f_cmd;
    a_dst   = rr ? r_dst   : f_dst;
    a_src   = rr ? r_src   : f_src;
    a_data  = rr ? r_data  : f_data;
    check({tag, ".valid"}, a_valid, ov);
    check({tag, ".ready"}, a_ready, rdy);
    if (p < 0) begin
      check({tag, ".data0"}, a_data, '0);
      check({tag, ".cmd0"}, a_cmd, '0);
    end else begin
      check({tag, ".cmd"}, a_cmd, pcmd(p, pe));
      check({tag, ".dst"}, a_dst, pdst(p));
      check({tag, ".src"}, a_src, psrc(p));
      check({tag, ".data"}, a_data, pdata(p));
    end
  endtask

  int rr_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    #2;
    expect_out("rst_idle_fix", 0, 1'b0, 4'b0000, -1, 1'b0);
    expect_out("rst_idle_rr", 1, 1'b0, 4'b0000, -1, 1'b0);
    drive(4'b1111, 4'b1111, 1'b1);
    #1;
    expect_out("rst_comb_fix", 0, 1'b1, 4'b0001, 0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fixed priority, everyone valid with single-beat packets.
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1111, 4'b1111, 1'b1);
      expect_out($sformatf("fix_all%0d", k), 0, 1'b1, 4'b0001, 0, 1'b1);
    end

    // Stall hold, then owner drops valid while port 2 keeps requesting.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0110, 4'b1111, 1'b0);
      expect_out($sformatf("stall%0d", k), 0, 1'b1, 4'b0000, 1, 1'b1);
    end
    cyc(4'b0100, 4'b1111, 1'b1);
    expect_out("drop_hold", 0, 1'b0, 4'b0010, 1, 1'b1);
    cyc(4'b0110, 4'b1111, 1'b1);
    expect_out("owner_eom", 0, 1'b1, 4'b0010, 1, 1'b1);
    cyc(4'b0100, 4'b1111, 1'b1);
    expect_out("after_eom_p2", 0, 1'b1, 4'b0100, 2, 1'b1);

    // Multi-beat packet from port 2; port 0 arrives mid-packet.
    do_reset();
    cyc(4'b0100, 4'b0000, 1'b1);
    expect_out("mb_beat1", 0, 1'b1, 4'b0100, 2, 1'b0);
    cyc(4'b0101, 4'b0000, 1'b1);
    expect_out("mb_beat2", 0, 1'b1, 4'b0100, 2, 1'b0);
    cyc(4'b0101, 4'b0101, 1'b1);
    expect_out("mb_beat3", 0, 1'b1, 4'b0100, 2, 1'b1);
    cyc(4'b0001, 4'b0001, 1'b1);
    expect_out("mb_p0", 0, 1'b1, 4'b0001, 0, 1'b1);

    // Round-robin rotation with all ports requesting.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1111, 4'b1111, 1'b1);
      expect_out($sformatf("rr_rot%0d", k), 1, 1'b1, 4'(1 << rr_order[k]),
                 rr_order[k], 1'b1);
    end

    // Masked set empty falls back to lowest request; mask then excludes port 0.
    do_reset();
    cyc(4'b0100, 4'b1111, 1'b1);
    expect_out("rr_p2", 1, 1'b1, 4'b0100, 2, 1'b1);
    cyc(4'b0011, 4'b1111, 1'b1);
    expect_out("rr_wrap_p0", 1, 1'b1, 4'b0001, 0, 1'b1);
    cyc(4'b0011, 4'b1111, 1'b1);
    expect_out("rr_next_p1", 1, 1'b1, 4'b0010, 1, 1'b1);

    // Reset while port 1 owns an open packet and the rr mask is not all ones.
    do_reset();
    cyc(4'b0001, 4'b1111, 1'b1);
    expect_out("mid_p0", 1, 1'b1, 4'b0001, 0, 1'b1);
    cyc(4'b0010, 4'b0000, 1'b1);
    expect_out("mid_p1_open", 1, 1'b1, 4'b0010, 1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(4'b0011, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'b0011, 4'b1111, 1'b1);
    #1;
    expect_out("post_rst_rr", 1, 1'b1, 4'b0001, 0, 1'b1);
    expect_out("post_rst_fix", 0, 1'b1, 4'b0001, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umi_arbiter.md
Name: umi_arbiter

Overview:
- N-input to 1-output UMI packet arbiter with valid/ready handshake on every port. It is the requester-facing side of the team's fixed-priority grant logic.
- Collects per-port valids and runs fixed-priority or round-robin selection, with index 0 highest priority.
- Locks the grant across a stalled beat and across multi-beat transactions until the EOM beat is accepted. It then muxes the winner onto the shared output.
- Sits in front of shared UMI links and crossbar output ports.

Parameters:
N, 4, number of input ports (N >= 2)
ROUNDROBIN, 0, 0 = fixed priority (index 0 highest); 1 = round-robin fairness
CW, 32, UMI command width; cmd[22] is EOM
AW, 64, address width
DW, 128, data width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
umi_in_valid  input  N  per-port valid
umi_in_cmd  input  N*CW  per-port command, port i at [i*CW +: CW]
umi_in_dstaddr  input  N*AW  per-port destination address
umi_in_srcaddr  input  N*AW  per-port source address
umi_in_data  input  N*DW  per-port data
umi_in_ready  output  N  per-port ready
umi_out_valid  output  1  output valid
umi_out_cmd  output  CW  muxed command
umi_out_dstaddr  output  AW  muxed destination address
umi_out_srcaddr  output  AW  muxed source address
umi_out_data  output  DW  muxed data
umi_out_ready  input  1  output ready

Behaviour:
- Clock, reset, and reset values:
  - One clock, clk. reset is synchronous and active-high.
  - On reset: lock = 0, locked_grant = 0, rr_mask = all ones.
  - Outputs are combinational, so during reset umi_out_valid follows the unlocked arbitration of umi_in_valid.
- Latency: zero-cycle combinational path from input to output. The only state is lock, locked_grant[N-1:0] and rr_mask[N-1:0].
- Unlocked arbitration (lock = 0):
  - req = umi_in_valid.
  - Fixed mode: grant = lowest set index of req.
  - RR mode: m = req & rr_mask. grant = lowest set index of m if m != 0, else lowest set index of req.
  - grant is one-hot or zero.
- Selection: sel = lock ? locked_grant : grant.
- Output path:
  - umi_out_valid = |(sel & umi_in_valid).
  - Payload fields are AND-OR muxed by sel. All payload fields are 0 when sel = 0.
- Input ready: umi_in_ready[i] = sel[i] & umi_out_ready. Unselected ports always see ready = 0.
- Lock set: on a cycle with umi_out_valid = 1 and (umi_out_ready = 0 or umi_out_cmd[22] = 0):
  - lock <= 1 and locked_grant <= sel.
  - Effect: a stalled beat and all non-EOM beats keep the same owner.
- Lock clear: on a cycle with umi_out_valid & umi_out_ready & umi_out_cmd[22]:
  - lock <= 0.
  - Arbitration is free in the following cycle.
- Round-robin update (ROUNDROBIN = 1 only):
  - On an accepted EOM beat from port g: rr_mask[j] <= (j > g).
  - If g = N-1, rr_mask <= all ones.
  - Non-EOM beats do not update rr_mask.
- Fixed mode: rr_mask is unused and constant.
- Locked owner drops valid: lock persists and umi_out_valid = 0. No other port is granted until the owner completes EOM. A valid drop is a protocol violation upstream, but the block must not glitch ownership.
- New requests while locked: ignored until unlock, with no effect on state.
- Simultaneous EOM-accept and new requests: the current beat completes with the current owner. The new winner is chosen next cycle using the updated rr_mask.
- Reset mid-packet: lock and rr_mask return to reset values, and the next cycle arbitrates fresh.

Test Plan:
- Fixed mode, N=4, all valid=1 with EOM=1, out_ready=1 -> port 0 wins every cycle, umi_in_ready=4'b0001, port 0 data appears on umi_out_data same cycle.
- Stall hold: valid=4'b0110, out_ready=0 for 3 cycles, then port 1 drops valid while port 2 holds -> ready=0 throughout, output stays port 1, no switch to port 2 until port 1 EOM accepted.
- Multi-beat: port 2 sends 3 beats (EOM only on beat 3) while port 0 asserts valid from beat 2 -> output sequence p2,p2,p2,p0; port 0 ready first asserts the cycle after the p2 EOM accept.
- Round-robin, all 4 valid with single-beat EOM, out_ready=1 -> grant order 0,1,2,3,0,1; rr_mask after port 3 equals 4'b1111.
- RR wrap with sparse requests: rr_mask=4'b1000 (after port 2), valid=4'b0011 -> masked set empty, falls back, port 0 granted; next rr_mask=4'b1110.
- Reset mid-packet: port 1 locked after a non-EOM beat, assert reset one cycle -> lock=0, rr_mask=1111; port 0 valid next cycle gets granted immediately.
